// File: rtl/fsk_demod_window.sv
// -----------------------------------------------------------------------------
// fsk_demod_window
//
// Window-counting FSK demodulator. Rising edges of the (asynchronous) FSK line
// are counted over fixed windows of WINDOW sysclk cycles. Each completed
// window is sliced into a mark (1) or space (0) bit. Windows with too few
// edges count towards a carrier-loss timeout. The first window is aligned to
// the first edge seen while enabled.
//
// Optional build macro: FSK_DEMOD_DEGLITCH_EN
//   Defined   : a 3-sample majority filter sits between the synchroniser and
//               the edge detector, rejecting 1-cycle high pulses (edge latency
//               grows by one cycle).
//   Undefined : the edge detector works on the plain synchronised line.
//
// Parameters
//   CNT_W        width of the edge counter and edge_count
//   WINDOW       window length in sysclk cycles (>= 2)
//   MARK_MIN     edges per window at or above which the bit is 1
//   SPACE_MIN    edges per window at or above which (below MARK_MIN) bit is 0
//                (1 <= SPACE_MIN <= MARK_MIN <= 2^CNT_W-1)
//   LOSS_WINDOWS consecutive sub-SPACE_MIN windows before carrier is lost (>= 1)
//
// Ports
//   sysclk       in   system clock, all logic on the rising edge
//   rst_n        in   asynchronous active-low reset
//   enable       in   synchronous soft enable
//   signal_in    in   raw FSK line, asynchronous to sysclk
//   signal_out   out  demodulated bit, idles at 1 (mark)
//   bit_valid    out  one-cycle strobe when signal_out takes a window decision
//   carrier_det  out  carrier present
//   edge_count   out  edge total of the last completed window
// -----------------------------------------------------------------------------
module fsk_demod_window #(
    parameter int CNT_W        = 10,
    parameter int WINDOW       = 16,
    parameter int MARK_MIN     = 6,
    parameter int SPACE_MIN    = 1,
    parameter int LOSS_WINDOWS = 2
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             signal_in,
    output logic             signal_out,
    output logic             bit_valid,
    output logic             carrier_det,
    output logic [CNT_W-1:0] edge_count
);

    localparam int WIN_W  = $clog2(WINDOW);
    localparam int LOSS_W = $clog2(LOSS_WINDOWS + 1);

    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  MARK_TH   = CNT_W'(MARK_MIN);
    localparam logic [CNT_W-1:0]  SPACE_TH  = CNT_W'(SPACE_MIN);
    localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_WINDOWS);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // -------------------------------------------------------------------------
    // Input path: two-flop synchroniser followed by a delay stage for the
    // edge detector.
    // -------------------------------------------------------------------------
    logic sync_meta;
    logic sync;
    logic sync_d;
    logic rise;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
            sync_d    <= 1'b0;
        end else begin
            sync_meta <= signal_in;
            sync      <= sync_meta;
            sync_d    <= sync;
        end
    end

`ifdef FSK_DEMOD_DEGLITCH_EN
    // Majority of three consecutive samples: an isolated single-cycle high
    // never wins the vote, while a steady level passes one cycle later.
    logic sync_d2;
    logic filt;
    logic filt_d;

    assign filt = (sync & sync_d) | (sync & sync_d2) | (sync_d & sync_d2);

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_d2 <= 1'b0;
            filt_d  <= 1'b0;
        end else begin
            sync_d2 <= sync_d;
            filt_d  <= filt;
        end
    end

    assign rise = filt & ~filt_d;
`else
    assign rise = sync & ~sync_d;
`endif

    // -------------------------------------------------------------------------
    // Window state
    // -------------------------------------------------------------------------
    logic [0:0]        state;
    logic [WIN_W-1:0]  win_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic [LOSS_W-1:0] loss_cnt;

    logic [CNT_W-1:0]  edge_inc;   // edge_cnt + 1, saturating
    logic [CNT_W-1:0]  total;      // window total including a closing-cycle rise
    logic              win_close;
    logic              is_mark;
    logic              is_space;
    logic [LOSS_W-1:0] loss_next;
    logic              loss_hit;

    assign edge_inc  = (edge_cnt == CNT_MAX) ? CNT_MAX : edge_cnt + CNT_W'(1);
    assign total     = rise ? edge_inc : edge_cnt;
    assign win_close = (state == ST_RUN) && (win_cnt == WIN_LAST);

    // Slicer: mark has priority; space only when below the mark threshold.
    assign is_mark   = (total >= MARK_TH);
    assign is_space  = !is_mark && (total >= SPACE_TH);

    assign loss_next = loss_cnt + LOSS_W'(1);
    assign loss_hit  = (loss_next == LOSS_LAST);

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            win_cnt     <= '0;
            edge_cnt    <= '0;
            loss_cnt    <= '0;
            signal_out  <= 1'b1;
            bit_valid   <= 1'b0;
            carrier_det <= 1'b0;
            edge_count  <= '0;
        end else begin
            bit_valid <= 1'b0;

            if (!enable) begin
                // Soft disable overrides everything, including a window that
                // would close this cycle. edge_count keeps its last value.
                state       <= ST_IDLE;
                win_cnt     <= '0;
                edge_cnt    <= '0;
                loss_cnt    <= '0;
                carrier_det <= 1'b0;
                signal_out  <= 1'b1;
            end else if (state == ST_IDLE) begin
                if (rise) begin
                    // The cycle carrying the first edge is cycle 0 of the
                    // window, and that edge is already counted.
                    state    <= ST_RUN;
                    win_cnt  <= WIN_W'(1);
                    edge_cnt <= CNT_W'(1);
                end else begin
                    win_cnt  <= '0;
                    edge_cnt <= '0;
                end
            end else if (win_close) begin
                edge_count <= total;
                win_cnt    <= '0;
                edge_cnt   <= '0;

                if (is_mark) begin
                    signal_out  <= 1'b1;
                    bit_valid   <= 1'b1;
                    carrier_det <= 1'b1;
                    loss_cnt    <= '0;
                end else if (is_space) begin
                    signal_out  <= 1'b0;
                    bit_valid   <= 1'b1;
                    carrier_det <= 1'b1;
                    loss_cnt    <= '0;
                end else if (loss_hit) begin
                    // Carrier gone: fall back to idle mark and wait for the
                    // next edge to realign the window.
                    carrier_det <= 1'b0;
                    signal_out  <= 1'b1;
                    loss_cnt    <= '0;
                    state       <= ST_IDLE;
                end else begin
                    loss_cnt <= loss_next;
                end
            end else begin
                win_cnt <= win_cnt + WIN_W'(1);
                if (rise) begin
                    edge_cnt <= edge_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_fsk_demod_window.sv
// -----------------------------------------------------------------------------
// tb_fsk_demod_window
//
// Bench for fsk_demod_window (WINDOW=16, MARK_MIN=6, SPACE_MIN=1,
// LOSS_WINDOWS=2, CNT_W=10). Every clock is checked against a window-level
// reference model built from the sampled input history; a table of steady
// waveforms and a few hand-written sequences add fixed expectations.
// Honours FSK_DEMOD_DEGLITCH_EN to select the matching reference behaviour.
// -----------------------------------------------------------------------------
module tb_fsk_demod_window;

    localparam int CNT_W        = 10;
    localparam int WINDOW       = 16;
    localparam int MARK_MIN     = 6;
    localparam int SPACE_MIN    = 1;
    localparam int LOSS_WINDOWS = 2;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;
    localparam int MAXC         = 8192;
`ifdef FSK_DEMOD_DEGLITCH_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic             sysclk;
    logic             rst_n;
    logic             enable;
    logic             signal_in;
    logic             signal_out;
    logic             bit_valid;
    logic             carrier_det;
    logic [CNT_W-1:0] edge_count;

    fsk_demod_window #(
        .CNT_W        (CNT_W),
        .WINDOW       (WINDOW),
        .MARK_MIN     (MARK_MIN),
        .SPACE_MIN    (SPACE_MIN),
        .LOSS_WINDOWS (LOSS_WINDOWS)
    ) dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .enable      (enable),
        .signal_in   (signal_in),
        .signal_out  (signal_out),
        .bit_valid   (bit_valid),
        .carrier_det (carrier_det),
        .edge_count  (edge_count)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int vectors = 0;
    int misc    = 0;

    // ---------------------------------------------------------------------
    // Reference model: history of what the DUT sampled on each edge, plus a
    // window described only by its starting cycle.
    // ---------------------------------------------------------------------
    bit samp [0:MAXC-1];
    bit enh  [0:MAXC-1];
    int cyc       = 8;
    int win_start = -1;   // -1 while idle
    int m_loss    = 0;
    bit m_sig     = 1'b1;
    bit m_bv      = 1'b0;
    bit m_cd      = 1'b0;
    int m_ec      = 0;

`ifdef FSK_DEMOD_DEGLITCH_EN
    function automatic bit maj_at(input int k);
        return (int'(samp[k-2]) + int'(samp[k-3]) + int'(samp[k-4])) >= 2;
    endfunction

    // Edge visible to the counter on the cycle that ends at edge k.
    function automatic int rise_at(input int k);
        return (maj_at(k) && !maj_at(k-1)) ? 1 : 0;
    endfunction
`else
    function automatic int rise_at(input int k);
        return (samp[k-2] && !samp[k-3]) ? 1 : 0;
    endfunction
`endif

    task automatic model_reset();
        win_start = -1;
        m_loss    = 0;
        m_sig     = 1'b1;
        m_bv      = 1'b0;
        m_cd      = 1'b0;
        m_ec      = 0;
    endtask

    task automatic model_edge(input int k);
        int tot;
        m_bv = 1'b0;
        if (!enh[k]) begin
            win_start = -1;
            m_cd      = 1'b0;
            m_sig     = 1'b1;
            m_loss    = 0;
        end else if (win_start < 0) begin
            if (rise_at(k) != 0) win_start = k;
        end else if (k == win_start + WINDOW - 1) begin
            tot = 0;
            for (int j = win_start; j <= k; j++) tot += rise_at(j);
            if (tot > CNT_MAX) tot = CNT_MAX;
            m_ec      = tot;
            win_start = k + 1;
            if (tot >= MARK_MIN) begin
                m_sig = 1'b1; m_bv = 1'b1; m_cd = 1'b1; m_loss = 0;
            end else if (tot >= SPACE_MIN) begin
                m_sig = 1'b0; m_bv = 1'b1; m_cd = 1'b1; m_loss = 0;
            end else begin
                m_loss++;
                if (m_loss == LOSS_WINDOWS) begin
                    m_cd = 1'b0; m_sig = 1'b1; m_loss = 0; win_start = -1;
                end
            end
        end
    endtask

    task automatic check_outputs(input string name);
        vectors++;
        if (signal_out !== m_sig || bit_valid !== m_bv ||
            carrier_det !== m_cd || int'(edge_count) != m_ec) begin
            misc++;
            $display("FAIL %s cyc=%0d: got sig=%b bv=%b cd=%b ec=%0d, expected sig=%b bv=%b cd=%b ec=%0d",
                     name, cyc, signal_out, bit_valid, carrier_det, edge_count,
                     m_sig, m_bv, m_cd, m_ec);
        end
    endtask

    task automatic expect_val(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            misc++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive at the falling edge, model the rising edge, compare at
    // the next falling edge.
    task automatic tick(input logic s, input logic e);
        signal_in = s;
        enable    = e;
        @(posedge sysclk);
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL history_overflow: got cyc %0d, limit %0d", cyc, MAXC);
            $fatal(1);
        end
        if (!rst_n) begin
            samp[cyc] = 1'b0;
            enh[cyc]  = 1'b0;
            model_reset();
        end else begin
            samp[cyc] = s;
            enh[cyc]  = e;
            model_edge(cyc);
        end
        @(negedge sysclk);
        check_outputs("tick");
    endtask

    task automatic async_reset(input string name);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        expect_val({name, "_signal_out"},  int'(signal_out),  1);
        expect_val({name, "_bit_valid"},   int'(bit_valid),   0);
        expect_val({name, "_carrier_det"}, int'(carrier_det), 0);
        expect_val({name, "_edge_count"},  int'(edge_count),  0);
        repeat (4) tick(1'b0, 1'b1);
        rst_n = 1'b1;
    endtask

    // ---------------------------------------------------------------------
    // Steady-waveform table
    // ---------------------------------------------------------------------
    typedef struct {
        int period;
        int high;
        int exp_ec;
        int exp_sig;
        int exp_cd;
    } row_t;

    row_t rows [5];

    initial begin
        int nbv;
        int ec_first;
        int ec_third;
        int sig_third;
        int got;
        int first_bv;

        for (int i = 0; i < MAXC; i++) begin
            samp[i] = 1'b0;
            enh[i]  = 1'b0;
        end

        rows[0] = '{2, 1, 8, 1, 1};
        rows[1] = '{4, 2, 4, 0, 1};
        rows[2] = '{8, 4, 2, 0, 1};
        rows[3] = '{16, 8, 1, 0, 1};
`ifdef FSK_DEMOD_DEGLITCH_EN
        // Isolated 1-cycle pulses never start a window: previous count holds.
        rows[4] = '{4, 1, 1, 1, 0};
`else
        rows[4] = '{4, 1, 4, 0, 1};
`endif

        rst_n     = 1'b0;
        enable    = 1'b0;
        signal_in = 1'b0;
        @(negedge sysclk);
        repeat (5) tick(1'b0, 1'b0);
        rst_n = 1'b1;
        tick(1'b0, 1'b0);

        // ---- table: each row starts from idle, runs 80 cycles of a wave ----
        for (int r = 0; r < 5; r++) begin
            tick(1'b0, 1'b0);
            tick(1'b0, 1'b0);
            for (int i = 0; i < 80; i++)
                tick((i % rows[r].period) >= (rows[r].period - rows[r].high), 1'b1);
            expect_val($sformatf("row%0d_edge_count", r),  int'(edge_count),  rows[r].exp_ec);
            expect_val($sformatf("row%0d_signal_out", r),  int'(signal_out),  rows[r].exp_sig);
            expect_val($sformatf("row%0d_carrier_det", r), int'(carrier_det), rows[r].exp_cd);
            $display("row %0d: period %0d high %0d -> edge_count %0d signal_out %b carrier_det %b",
                     r, rows[r].period, rows[r].high, edge_count, signal_out, carrier_det);
        end

        // ---- period 2 -> period 4 transition ----
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 48; i++) tick((i % 2) == 1, 1'b1);
        nbv = 0; ec_first = -1; ec_third = -1; sig_third = -1;
        for (int i = 0; i < 80 && nbv < 3; i++) begin
            tick((i % 4) >= 2, 1'b1);
            if (bit_valid) begin
                nbv++;
                if (nbv == 1) ec_first = int'(edge_count);
                if (nbv == 3) begin
                    ec_third  = int'(edge_count);
                    sig_third = int'(signal_out);
                end
            end
        end
        expect_val("switch_windows_seen", nbv, 3);
        expect_val("switch_mixed_in_4_to_8", int'(ec_first >= 4 && ec_first <= 8), 1);
        expect_val("switch_p4_edge_count", ec_third, 4);
        expect_val("switch_p4_signal_out", sig_third, 0);
        $display("transition: first count %0d, settled count %0d", ec_first, ec_third);

        // ---- asynchronous reset while running ----
        for (int i = 0; i < 7; i++) tick((i % 4) >= 2, 1'b1);
        async_reset("rst_mid_run");
        $display("async reset applied mid-window");

        // ---- carrier loss ----
        tick(1'b0, 1'b0);
        for (int i = 0; i < 48; i++) tick((i % 2) == 1, 1'b1);
        expect_val("loss_pre_carrier", int'(carrier_det), 1);
        for (int i = 0; i < 70; i++) tick(1'b0, 1'b1);
        expect_val("loss_carrier_det", int'(carrier_det), 0);
        expect_val("loss_signal_out",  int'(signal_out),  1);
        expect_val("loss_edge_count",  int'(edge_count),  0);
        nbv = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 1'b1);
            nbv += int'(bit_valid);
        end
        expect_val("loss_quiet_bit_valid", nbv, 0);
        $display("carrier loss: carrier_det %b signal_out %b", carrier_det, signal_out);

        // ---- enable drop at win_cnt 9, then restart ----
        got = 0;
        for (int i = 0; i < 60 && got == 0; i++) begin
            tick((i % 2) == 1, 1'b1);
            if (bit_valid) got = 1;
        end
        expect_val("drop_sync_bit_valid", got, 1);
        for (int i = 1; i <= 6; i++) tick((i % 2) == 1, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        expect_val("drop_carrier_det", int'(carrier_det), 0);
        nbv = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b1);
            nbv += int'(bit_valid);
        end
        expect_val("drop_no_bit_valid", nbv, 0);
        first_bv = -1;
        for (int j = 0; j < 40; j++) begin
            tick((j % 8) < 4, 1'b1);
            if (bit_valid && first_bv < 0) first_bv = j;
        end
        expect_val("restart_bit_valid_latency", first_bv, 17 + LAT);
        $display("enable drop: restart bit_valid after %0d cycles", first_bv);

        // ---- randomized segments against the model ----
        for (int seg = 0; seg < 30; seg++) begin
            int per;
            int hi;
            int len;
            int mode;
            logic s;
            logic e;
            mode = $urandom_range(0, 9);
            per  = $urandom_range(2, 20);
            hi   = $urandom_range(1, per - 1);
            len  = $urandom_range(20, 80);
            if (mode == 0) async_reset("rnd_rst");
            for (int i = 0; i < len; i++) begin
                if (mode == 1)      s = ($urandom_range(0, 1) == 1);
                else if (mode == 2) s = 1'b0;
                else                s = (i % per) >= (per - hi);
                e = ($urandom_range(0, 39) != 0);
                tick(s, e);
            end
            $display("random seg %0d: mode %0d period %0d high %0d len %0d", seg, mode, per, hi, len);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish by time %0t, expected finish earlier", $time);
        $fatal(1);
    end

endmodule
